mu0_control: RTL

//  Fetch/execute control FSM for the MU0 datapath, directly upstream of the ALU.

---
 rtl/mu0_control.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mu0_control.sv
// mu0_control: fetch/execute control FSM for the MU0 datapath.
// Decodes opcode F and accumulator flags N/Z into ALU mode, mux selects,
// register enables and memory strobes, and keeps a saturating count of
// completed instructions.
//
// Ports:
//   Clk, Reset        clock (rising edge), asynchronous active-low reset
//   F[3:0], N, Z      opcode (IR[15:12]), Acc negative flag, Acc zero flag
//   Step              single-step release (only with MU0_STEP_EN)
//   X_sel, Y_sel      ALU X source (0=PC,1=Acc), Y source (0=mem,1=IR)
//   Addr_sel          memory address source (0=PC,1=IR[11:0])
//   PC_En/IR_En/Acc_En register load enables
//   Rd, Wr            memory strobes
//   M[1:0]            ALU mode: 00 Q=Y, 01 X+Y, 10 X+1, 11 X-Y
//   Halted            high while in HALT
//   InstCount         saturating count of completed instructions
//
// Optional feature: define MU0_STEP_EN to add the Step input and a STEPWAIT
// state entered after every non-STP instruction.
//
// Only the state and InstCount are registered; all other outputs decode
// combinationally from state, F, N and Z.

module mu0_control #(
    parameter int unsigned ICNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [3:0]        F,
`ifdef MU0_STEP_EN
    input  logic              Step,
`endif
    input  logic              N,
    input  logic              Z,
    output logic              X_sel,
    output logic              Y_sel,
    output logic              Addr_sel,
    output logic              PC_En,
    output logic              IR_En,
    output logic              Acc_En,
    output logic              Rd,
    output logic              Wr,
    output logic [1:0]        M,
    output logic              Halted,
    output logic [ICNT_W-1:0] InstCount
);

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] M_PASS_Y = 2'b00;
    localparam logic [1:0] M_ADD    = 2'b01;
    localparam logic [1:0] M_INC    = 2'b10;
    localparam logic [1:0] M_SUB    = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXECUTE  = 2'd1,
        S_HALT     = 2'd2,
        S_STEPWAIT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ICNT_W-1:0]   r_icnt;

    logic       w_x_sel, w_y_sel, w_addr_sel;
    logic       w_pc_en, w_ir_en, w_acc_en;
    logic       w_rd, w_wr, w_halted;
    logic [1:0] w_m;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction counter: every EXECUTE cycle completes an instruction; holds at all-ones
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_icnt <= '0;
        end else if ((r_state == S_EXECUTE) && (r_icnt != {ICNT_W{1'b1}})) begin
            r_icnt <= r_icnt + ICNT_W'(1);
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        w_x_sel    = 1'b0;
        w_y_sel    = 1'b0;
        w_addr_sel = 1'b0;
        w_pc_en    = 1'b0;
        w_ir_en    = 1'b0;
        w_acc_en   = 1'b0;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_m        = M_PASS_Y;
        w_halted   = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Read instruction at PC into IR while PC <= PC+1
                w_addr_sel = 1'b0;
                w_rd       = 1'b1;
                w_ir_en    = 1'b1;
                w_x_sel    = 1'b0;
                w_m        = M_INC;
                w_pc_en    = 1'b1;
                w_next     = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (F)
                    OP_LDA: begin
                        w_addr_sel = 1'b1;
                        w_rd       = 1'b1;
                        w_m        = M_PASS_Y;
                        w_acc_en   = 1'b1;
                    end
                    OP_STA: begin
                        w_addr_sel = 1'b1;
                        w_wr       = 1'b1;
                        w_x_sel    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_addr_sel = 1'b1;
                        w_rd       = 1'b1;
                        w_x_sel    = 1'b1;
                        w_m        = (F == OP_ADD) ? M_ADD : M_SUB;
                        w_acc_en   = 1'b1;
                    end
                    OP_JMP: begin
                        w_y_sel = 1'b1;
                        w_pc_en = 1'b1;
                    end
                    OP_JGE: begin
                        w_y_sel = !N;
                        w_pc_en = !N;
                    end
                    OP_JNE: begin
                        w_y_sel = !Z;
                        w_pc_en = !Z;
                    end
                    default: ;
                endcase
                if (F == OP_STP) begin
                    w_next = S_HALT;
                end else begin
`ifdef MU0_STEP_EN
                    w_next = S_STEPWAIT;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
`ifdef MU0_STEP_EN
            S_STEPWAIT: begin
                if (Step) begin
                    w_next = S_FETCH;
                end
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset held low suppresses every enable and strobe immediately
        if (!Reset) begin
            w_pc_en  = 1'b0;
            w_ir_en  = 1'b0;
            w_acc_en = 1'b0;
            w_rd     = 1'b0;
            w_wr     = 1'b0;
        end
    end

    assign X_sel     = w_x_sel;
    assign Y_sel     = w_y_sel;
    assign Addr_sel  = w_addr_sel;
    assign PC_En     = w_pc_en;
    assign IR_En     = w_ir_en;
    assign Acc_En    = w_acc_en;
    assign Rd        = w_rd;
    assign Wr        = w_wr;
    assign M         = w_m;
    assign Halted    = w_halted;
    assign InstCount = r_icnt;

endmodule
